cla_seq_adder_ctrl: RTL and testbench



---
 rtl/cla_seq_pkg.sv | 15 +
 rtl/cla_gp_8_bit.sv | 39 +++
 rtl/cla_seq_adder_ctrl.sv | 113 +++++++++++
 tb/tb_cla_seq_adder_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// Shared constants for the byte-serial CLA add/subtract controller.
package cla_seq_pkg;

  localparam int unsigned CHUNK_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla_gp_8_bit.sv
// 8-bit carry-lookahead slice: sum, per-bit carry-outs and group generate/propagate.
module cla_gp_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c0,
  output logic [7:0] s,
  output logic [7:0] c,
  output logic       g,
  output logic       p
);

  logic [7:0] gi;
  logic [7:0] pi;

  assign gi = a & b;
  assign pi = a ^ b;

  // Each carry is expanded as a flat lookahead term over all lower bits.
  always_comb begin
    logic grp;
    logic prop;
    c = '0;
    g = 1'b0;
    for (int i = 0; i < 8; i++) begin
      grp  = 1'b0;
      prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        grp  = grp | (prop & gi[j]);
        prop = prop & pi[j];
      end
      c[i] = grp | (prop & c0);
      if (i == 7) g = grp;
    end
  end

  assign p = &pi;
  assign s = pi ^ {c[6:0], c0};

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// WIDTH-bit add/subtract built by running one 8-bit CLA slice over the operand
// one byte per cycle, LSB first, with valid/ready request and response ports.
module cla_seq_adder_ctrl
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK_W;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [CHUNK_W-1:0] slice_s;
  logic [CHUNK_W-1:0] slice_c;
  logic               slice_g_unused;
  logic               slice_p_unused;
  logic [5:0]         slice_c_low_unused;
  logic [WIDTH-1:0]   sum_next;

  cla_gp_8_bit u_slice (
    .a  (a_q[CHUNK_W-1:0]),
    .b  (b_q[CHUNK_W-1:0]),
    .c0 (carry_q),
    .s  (slice_s),
    .c  (slice_c),
    .g  (slice_g_unused),
    .p  (slice_p_unused)
  );

  assign slice_c_low_unused = slice_c[5:0];

  // Operands shift down a byte per pass; the sum fills in from the top so it
  // lands fully aligned after the last chunk.
  assign sum_next = WIDTH'({slice_s, sum_q} >> CHUNK_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= in_a;
            b_q      <= (in_op == OP_SUB) ? ~in_b : in_b;
            carry_q  <= (in_op == OP_ADD) ? 1'b0 : 1'b1;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK_W;
          b_q     <= b_q >> CHUNK_W;
          sum_q   <= sum_next;
          carry_q <= slice_c[7];
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CHUNK) begin
            out_sum   <= sum_next;
            out_carry <= slice_c[7];
            out_ovf   <= slice_c[6] ^ slice_c[7];
            out_zero  <= (sum_next == '0);
            out_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Randomized and directed checks of cla_seq_adder_ctrl against an arithmetic model.
module tb_cla_seq_adder_ctrl;

  localparam int unsigned W   = 32;
  localparam int unsigned NCH = W / 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_ovf;
  logic         out_zero;

  cla_seq_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic result: {zero, ovf, carry, sum}
  function automatic logic [W+2:0] ref_op(input logic op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic         ovf;
    bb  = op ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + (W+1)'(op);
    ovf = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return {(r[W-1:0] == '0), ovf, r[W], r[W-1:0]};
  endfunction

  // Transaction-level model: idle -> busy for NCH edges -> done until out_ready.
  int           m_state;
  int           m_left;
  logic [W+2:0] m_pend;
  logic [W-1:0] m_sum;
  logic         m_c, m_o, m_z;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_left  <= 0;
      m_pend  <= '0;
      m_sum   <= '0;
      m_c     <= 1'b0;
      m_o     <= 1'b0;
      m_z     <= 1'b0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
             m_pend  <= ref_op(in_op, in_a, in_b);
             m_left  <= NCH;
             m_state <= 1;
           end
        1: begin
             m_left <= m_left - 1;
             if (m_left == 1) begin
               m_sum   <= m_pend[W-1:0];
               m_c     <= m_pend[W];
               m_o     <= m_pend[W+1];
               m_z     <= m_pend[W+2];
               m_state <= 2;
             end
           end
        default: if (out_ready) m_state <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk1("in_ready", in_ready, 1'(m_state == 0));
    chk1("out_valid", out_valid, 1'(m_state == 2));
    chkw("out_sum", out_sum, m_sum);
    chk1("out_carry", out_carry, m_c);
    chk1("out_ovf", out_ovf, m_o);
    chk1("out_zero", out_zero, m_z);
  end

  task automatic run(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int hold, input bit lit, input logic [W-1:0] es,
                     input logic ec, input logic eo, input logic ez);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk1("accept_wait", in_ready, 1'b1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Scramble inputs after acceptance; they must not affect the result.
    in_valid = 1'($urandom);
    in_op    = 1'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin
      in_a = W'($urandom);
      in_b = W'($urandom);
      @(negedge clk);
      n++;
    end
    chki("latency", n, NCH);
    if (lit) begin
      chkw("lit_sum", out_sum, es);
      chk1("lit_carry", out_carry, ec);
      chk1("lit_ovf", out_ovf, eo);
      chk1("lit_zero", out_zero, ez);
    end
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      @(negedge clk);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_out_valid", out_valid, 1'b1);
      if (lit) chkw("bp_sum", out_sum, es);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1("ret_in_ready", in_ready, 1'b1);
    chk1("ret_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chkw("rst_out_sum", out_sum, '0);
    rst_n = 1'b1;

    run(1'b0, 32'h00000001, 32'h00000001, 0, 1, 32'h00000002, 1'b0, 1'b0, 1'b0);
    run(1'b0, 32'h00FFFFFF, 32'h00000001, 0, 1, 32'h01000000, 1'b0, 1'b0, 1'b0);
    run(1'b0, 32'hFFFFFFFF, 32'h00000001, 0, 1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run(1'b0, 32'h7FFFFFFF, 32'h00000001, 0, 1, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run(1'b1, 32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    run(1'b1, 32'h00000005, 32'h00000007, 0, 1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run(1'b1, 32'h12345678, 32'h12345678, 0, 1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    // Long backpressure with new requests offered, then a fresh op.
    run(1'b0, 32'h11111111, 32'h22222222, 10, 1, 32'h33333333, 1'b0, 1'b0, 1'b0);
    run(1'b1, 32'h00000010, 32'h00000001, 0, 1, 32'h0000000F, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of RUN (chunk 2).
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 1'b0;
    in_a     = 32'hDEADBEEF;
    in_b     = 32'h01010101;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("midrst_in_ready", in_ready, 1'b1);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chkw("midrst_out_sum", out_sum, '0);
    chk1("midrst_out_carry", out_carry, 1'b0);
    chk1("midrst_out_ovf", out_ovf, 1'b0);
    chk1("midrst_out_zero", out_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 32'h00000003, 32'h00000004, 0, 1, 32'h00000007, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with corner-biased operands and random backpressure.
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'hFFFFFFFF;
        1:       ra = 32'h80000000;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       rb = 32'h00000001;
        1:       rb = ra;
        default: rb = W'($urandom);
      endcase
      run(1'($urandom), ra, rb, int'($urandom_range(0, 3)), 0, '0, 1'b0, 1'b0, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
